mbist_sti_seq: RTL

//  Parametrised MBIST stimulus sequencer: steps through up to BIST_STI_SIZE march stimuli,

---
 rtl/mbist_pkg.sv | 37 +++
 rtl/mbist_sti_find.sv | 33 +++
 rtl/mbist_sti_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mbist_pkg.sv
// Shared MBIST definitions: sequencer state encoding and the march stimulus table.
package mbist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sti_state_e;

  localparam int BIST_STI_MAX = 16;

  localparam logic [15:0] BIST_STIMULUS_TYPE1  = 16'h0C31;
  localparam logic [15:0] BIST_STIMULUS_TYPE2  = 16'h1C32;
  localparam logic [15:0] BIST_STIMULUS_TYPE3  = 16'h2A33;
  localparam logic [15:0] BIST_STIMULUS_TYPE4  = 16'h3A34;
  localparam logic [15:0] BIST_STIMULUS_TYPE5  = 16'h4535;
  localparam logic [15:0] BIST_STIMULUS_TYPE6  = 16'h5536;
  localparam logic [15:0] BIST_STIMULUS_TYPE7  = 16'h6937;
  localparam logic [15:0] BIST_STIMULUS_TYPE8  = 16'h7938;
  localparam logic [15:0] BIST_STIMULUS_TYPE9  = 16'h0D39;
  localparam logic [15:0] BIST_STIMULUS_TYPE10 = 16'h1D3A;
  localparam logic [15:0] BIST_STIMULUS_TYPE11 = 16'h2B3B;
  localparam logic [15:0] BIST_STIMULUS_TYPE12 = 16'h3B3C;
  localparam logic [15:0] BIST_STIMULUS_TYPE13 = 16'h463D;
  localparam logic [15:0] BIST_STIMULUS_TYPE14 = 16'h563E;
  localparam logic [15:0] BIST_STIMULUS_TYPE15 = 16'h6A3F;
  localparam logic [15:0] BIST_STIMULUS_TYPE16 = 16'h7A40;

  // Words are stored at full 16-bit width; users slice to their stimulus width.
  localparam logic [15:0] BIST_STI_TABLE [BIST_STI_MAX] = '{
    BIST_STIMULUS_TYPE1,  BIST_STIMULUS_TYPE2,  BIST_STIMULUS_TYPE3,  BIST_STIMULUS_TYPE4,
    BIST_STIMULUS_TYPE5,  BIST_STIMULUS_TYPE6,  BIST_STIMULUS_TYPE7,  BIST_STIMULUS_TYPE8,
    BIST_STIMULUS_TYPE9,  BIST_STIMULUS_TYPE10, BIST_STIMULUS_TYPE11, BIST_STIMULUS_TYPE12,
    BIST_STIMULUS_TYPE13, BIST_STIMULUS_TYPE14, BIST_STIMULUS_TYPE15, BIST_STIMULUS_TYPE16
  };

endpackage

// File: rtl/mbist_sti_find.sv
// Combinational priority search over the stimulus enable mask: lowest set bit,
// next set bit strictly above the current index, and whether any bit is set.
module mbist_sti_find #(
  parameter int SIZE = 8,
  parameter int IW   = $clog2(SIZE)
) (
  input  logic [SIZE-1:0] i_mask,
  input  logic [IW-1:0]   i_idx,
  output logic [IW-1:0]   o_first_idx,
  output logic [IW-1:0]   o_next_idx,
  output logic            o_has_next,
  output logic            o_any_set
);

  // Scanning downward lets the last hit be the lowest qualifying bit.
  always_comb begin
    o_first_idx = '0;
    o_next_idx  = '0;
    o_has_next  = 1'b0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_first_idx = IW'(i);
        if (IW'(i) > i_idx) begin
          o_next_idx = IW'(i);
          o_has_next = 1'b1;
        end
      end
    end
  end

  assign o_any_set = |i_mask;

endmodule

// File: rtl/mbist_sti_seq.sv
// MBIST stimulus sequencer: walks enabled march stimuli via start/next/done.
// Define MBIST_STI_LOOP_EN to repeat the enabled set BIST_LOOP_CNT times before done.
module mbist_sti_seq
  import mbist_pkg::*;
#(
  parameter int BIST_STI_SIZE = 8,
  parameter int BIST_STI_WD   = 15,
  parameter int BIST_LOOP_CNT = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             scan_shift,
  input  logic                             sdi,
  output logic                             sdo,
  input  logic                             start,
  input  logic                             next,
  output logic                             sti_valid,
  output logic [$clog2(BIST_STI_SIZE)-1:0] sti_idx,
  output logic [BIST_STI_WD-1:0]           stimulus,
  output logic                             last_stimulus,
  output logic                             done,
  output logic [3:0]                       loop_cnt,
  output logic [1:0]                       dbg_state
);

  localparam int SIZE = BIST_STI_SIZE;
  localparam int IW   = $clog2(BIST_STI_SIZE);

  if (SIZE < 2 || SIZE > 16 || BIST_STI_WD > 16 || BIST_LOOP_CNT < 1 || BIST_LOOP_CNT > 15)
  begin : g_param_check
    $error("mbist_sti_seq: parameter out of range");
  end

  sti_state_e      r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [SIZE-1:0] r_mask, w_mask_nxt;
  logic [IW-1:0]   w_first_idx, w_next_idx;
  logic            w_has_next, w_any_set, w_final_pass;

  mbist_sti_find #(.SIZE(SIZE), .IW(IW)) u_find (
    .i_mask      (r_mask),
    .i_idx       (r_idx),
    .o_first_idx (w_first_idx),
    .o_next_idx  (w_next_idx),
    .o_has_next  (w_has_next),
    .o_any_set   (w_any_set)
  );

`ifdef MBIST_STI_LOOP_EN
  logic [3:0] r_loop, w_loop_nxt;
  assign w_final_pass = (r_loop == 4'(BIST_LOOP_CNT - 1));
  assign loop_cnt     = r_loop;

  always_ff @(posedge clk) begin
    if (!rst_n) r_loop <= 4'd0;
    else        r_loop <= w_loop_nxt;
  end
`else
  assign w_final_pass = 1'b1;
  assign loop_cnt     = 4'd0;
`endif

  // Scan has priority over start, start over next; next only acts in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mask_nxt  = r_mask;
`ifdef MBIST_STI_LOOP_EN
    w_loop_nxt  = r_loop;
`endif
    if (scan_shift) begin
      w_mask_nxt  = {sdi, r_mask[SIZE-1:1]};
      w_state_nxt = IDLE;
`ifdef MBIST_STI_LOOP_EN
      w_loop_nxt  = 4'd0;
`endif
    end else if (start) begin
      w_state_nxt = w_any_set ? RUN : DONE;
      if (w_any_set) w_idx_nxt = w_first_idx;
`ifdef MBIST_STI_LOOP_EN
      w_loop_nxt  = 4'd0;
`endif
    end else if (next && r_state == RUN) begin
      if (w_has_next) begin
        w_idx_nxt = w_next_idx;
      end else if (!w_final_pass) begin
        w_idx_nxt = w_first_idx;
`ifdef MBIST_STI_LOOP_EN
        w_loop_nxt = r_loop + 4'd1;
`endif
      end else begin
        w_state_nxt = DONE;
`ifdef MBIST_STI_LOOP_EN
        w_loop_nxt  = 4'(BIST_LOOP_CNT);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_mask  <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  // All outputs decode registered state only.
  assign sti_valid     = (r_state == RUN);
  assign done          = (r_state == DONE);
  assign sti_idx       = r_idx;
  assign sdo           = r_mask[0];
  assign last_stimulus = sti_valid && !w_has_next && w_final_pass;
  assign stimulus      = sti_valid ? BIST_STI_TABLE[4'(r_idx)][BIST_STI_WD-1:0]
                                   : BIST_STIMULUS_TYPE1[BIST_STI_WD-1:0];
  assign dbg_state     = r_state;

endmodule
